// File: rtl/brcomp_arbiter.sv
// Shares one combinational branch comparator between the EX branch resolver and the SLT path.
// Accept in N, compare in N+1, response in N+2 and held until consumed; BRARB_BRANCH_PRIO_EN selects fixed branch priority.
module brcomp_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_req_valid,
  output logic            br_req_ready,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_rs1_data,
  input  logic [XLEN-1:0] br_rs2_data,
  output logic            br_rsp_valid,
  input  logic            br_rsp_ready,
  output logic            br_taken,
  output logic            br_illegal,
  input  logic            slt_req_valid,
  output logic            slt_req_ready,
  input  logic            slt_unsigned,
  input  logic [XLEN-1:0] slt_rs1_data,
  input  logic [XLEN-1:0] slt_rs2_data,
  output logic            slt_rsp_valid,
  input  logic            slt_rsp_ready,
  output logic            slt_result,
  output logic [XLEN-1:0] comp_rs1_data,
  output logic [XLEN-1:0] comp_rs2_data,
  output logic            comp_unsigned,
  input  logic            comp_less,
  input  logic            comp_equal
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t            r_state;
  logic              r_owner_slt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic              r_unsigned;
  logic              r_br_rsp_valid;
  logic              r_slt_rsp_valid;
  logic              r_br_taken;
  logic              r_br_illegal;
  logic              r_slt_result;

  logic              w_sel_br;
  logic              w_idle;
  logic              w_br_hs;
  logic              w_slt_hs;
  logic              w_taken;
  logic              w_illegal;

`ifdef BRARB_BRANCH_PRIO_EN
  // SLT only wins an IDLE cycle in which the branch side is not asking.
  assign w_sel_br = br_req_valid | ~slt_req_valid;
`else
  logic r_ptr_slt;

  always_comb begin
    w_sel_br = ~r_ptr_slt;
    if (br_req_valid && !slt_req_valid) begin
      w_sel_br = 1'b1;
    end else if (!br_req_valid && slt_req_valid) begin
      w_sel_br = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_slt <= 1'b0;
    end else if (w_br_hs) begin
      r_ptr_slt <= 1'b1;
    end else if (w_slt_hs) begin
      r_ptr_slt <= 1'b0;
    end
  end
`endif

  assign w_idle        = (r_state == S_IDLE) && !rst;
  assign br_req_ready  = w_idle && w_sel_br;
  assign slt_req_ready = w_idle && !w_sel_br;
  assign w_br_hs       = br_req_valid && br_req_ready;
  assign w_slt_hs      = slt_req_valid && slt_req_ready;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (r_funct3)
      3'b000:         w_taken   = comp_equal;
      3'b001:         w_taken   = !comp_equal;
      3'b100, 3'b110: w_taken   = comp_less;
      3'b101, 3'b111: w_taken   = !comp_less;
      default:        w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_owner_slt     <= 1'b0;
      r_funct3        <= 3'b000;
      r_rs1           <= '0;
      r_rs2           <= '0;
      r_unsigned      <= 1'b0;
      r_br_rsp_valid  <= 1'b0;
      r_slt_rsp_valid <= 1'b0;
      r_br_taken      <= 1'b0;
      r_br_illegal    <= 1'b0;
      r_slt_result    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_br_hs) begin
            r_rs1       <= br_rs1_data;
            r_rs2       <= br_rs2_data;
            r_funct3    <= br_funct3;
            r_unsigned  <= br_funct3[1];
            r_owner_slt <= 1'b0;
            r_state     <= S_CMP;
          end else if (w_slt_hs) begin
            r_rs1       <= slt_rs1_data;
            r_rs2       <= slt_rs2_data;
            r_unsigned  <= slt_unsigned;
            r_owner_slt <= 1'b1;
            r_state     <= S_CMP;
          end
        end
        S_CMP: begin
          if (r_owner_slt) begin
            r_slt_result    <= comp_less;
            r_slt_rsp_valid <= 1'b1;
          end else begin
            r_br_taken     <= w_taken;
            r_br_illegal   <= w_illegal;
            r_br_rsp_valid <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if ((r_br_rsp_valid && br_rsp_ready) || (r_slt_rsp_valid && slt_rsp_ready)) begin
            r_br_rsp_valid  <= 1'b0;
            r_slt_rsp_valid <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Comparator inputs come straight from the capture registers, never from the request ports.
  assign comp_rs1_data = r_rs1;
  assign comp_rs2_data = r_rs2;
  assign comp_unsigned = r_unsigned;

  assign br_rsp_valid  = r_br_rsp_valid;
  assign br_taken      = r_br_taken;
  assign br_illegal    = r_br_illegal;
  assign slt_rsp_valid = r_slt_rsp_valid;
  assign slt_result    = r_slt_result;

endmodule

// File: tb/tb_brcomp_arbiter.sv
// Bench for brcomp_arbiter: directed vectors, arbitration/backpressure/reset sequences, randomized scoreboard.
module tb_brcomp_arbiter;
  localparam int XLEN = 32;
`ifdef BRARB_BRANCH_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br_req_valid = 1'b0, br_req_ready;
  logic [2:0] br_funct3 = 3'b000;
  logic [XLEN-1:0] br_rs1_data = '0, br_rs2_data = '0;
  logic br_rsp_valid, br_rsp_ready = 1'b1, br_taken, br_illegal;
  logic slt_req_valid = 1'b0, slt_req_ready;
  logic slt_unsigned = 1'b0;
  logic [XLEN-1:0] slt_rs1_data = '0, slt_rs2_data = '0;
  logic slt_rsp_valid, slt_rsp_ready = 1'b1, slt_result;
  logic [XLEN-1:0] comp_rs1_data, comp_rs2_data;
  logic comp_unsigned, comp_less, comp_equal;

  always #5 clk = ~clk;

  // External comparator behaviour.
  assign comp_equal = (comp_rs1_data == comp_rs2_data);
  assign comp_less  = comp_unsigned ? (comp_rs1_data < comp_rs2_data)
                                    : ($signed(comp_rs1_data) < $signed(comp_rs2_data));

  brcomp_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .br_req_valid(br_req_valid), .br_req_ready(br_req_ready), .br_funct3(br_funct3),
    .br_rs1_data(br_rs1_data), .br_rs2_data(br_rs2_data),
    .br_rsp_valid(br_rsp_valid), .br_rsp_ready(br_rsp_ready),
    .br_taken(br_taken), .br_illegal(br_illegal),
    .slt_req_valid(slt_req_valid), .slt_req_ready(slt_req_ready), .slt_unsigned(slt_unsigned),
    .slt_rs1_data(slt_rs1_data), .slt_rs2_data(slt_rs2_data),
    .slt_rsp_valid(slt_rsp_valid), .slt_rsp_ready(slt_rsp_ready), .slt_result(slt_result),
    .comp_rs1_data(comp_rs1_data), .comp_rs2_data(comp_rs2_data), .comp_unsigned(comp_unsigned),
    .comp_less(comp_less), .comp_equal(comp_equal)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RISC-V branch semantics by mnemonic.
  function automatic logic [1:0] br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return {a == b, 1'b0};
      3'd1: return {a != b, 1'b0};
      3'd4: return {sa < sb, 1'b0};
      3'd5: return {sa >= sb, 1'b0};
      3'd6: return {a < b, 1'b0};
      3'd7: return {a >= b, 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic slt_model(input logic uns, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    return uns ? (a < b) : (sa < sb);
  endfunction

  typedef struct packed {
    logic        is_br;
    logic [2:0]  f3;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic        res;
    logic        ill;
    logic        cu;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    br_req_valid  = v.is_br;
    slt_req_valid = !v.is_br;
    br_funct3     = v.f3;
    slt_unsigned  = v.uns;
    br_rs1_data   = v.is_br ? v.a : $urandom;
    br_rs2_data   = v.is_br ? v.b : $urandom;
    slt_rs1_data  = v.is_br ? $urandom : v.a;
    slt_rs2_data  = v.is_br ? $urandom : v.b;
    #1;
    chk($sformatf("v%0d_req_ready", idx), 32'(v.is_br ? br_req_ready : slt_req_ready), 32'd1);
    @(negedge clk);
    br_req_valid  = 1'b0;
    slt_req_valid = 1'b0;
    br_rs1_data   = $urandom;
    slt_rs1_data  = $urandom;
    br_funct3     = 3'($urandom_range(0, 7));
    #1;
    chk($sformatf("v%0d_comp_rs1", idx), comp_rs1_data, v.a);
    chk($sformatf("v%0d_comp_rs2", idx), comp_rs2_data, v.b);
    chk($sformatf("v%0d_comp_unsigned", idx), 32'(comp_unsigned), 32'(v.cu));
    chk($sformatf("v%0d_cmp_quiet", idx),
        32'({br_req_ready, slt_req_ready, br_rsp_valid, slt_rsp_valid}), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_valid", idx), 32'({br_rsp_valid, slt_rsp_valid}),
        v.is_br ? 32'd2 : 32'd1);
    if (v.is_br) chk($sformatf("v%0d_taken_illegal", idx), 32'({br_taken, br_illegal}), 32'({v.res, v.ill}));
    else         chk($sformatf("v%0d_slt_result", idx), 32'(slt_result), 32'(v.res));
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_done", idx), 32'({br_rsp_valid, slt_rsp_valid}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tot=%0d", n_tot);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_br, seen, busy, own_br, rr_br, wbr;
    int g_cnt, acc_k, age;
    logic [1:0] exp_bt;
    logic exp_sr;

    vecs[0]  = '{1'b1, 3'b000, 1'b0, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'b000, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'b000, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'b011, 1'b0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3'b001, 1'b0, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b101, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'b111, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'b010, 1'b0, 32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'b000, 1'b1, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b1};

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'({br_req_ready, slt_req_ready}), 32'd0);
    chk("rst_rsp", 32'({br_rsp_valid, slt_rsp_valid, br_taken, br_illegal, slt_result}), 32'd0);
    chk("rst_comp", comp_rs1_data | comp_rs2_data | 32'(comp_unsigned), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready_ptr_branch", 32'({br_req_ready, slt_req_ready}), 32'd2);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Both requesters valid continuously from reset.
    pulse_reset();
    br_req_valid = 1'b1;  br_funct3 = 3'b000;
    slt_req_valid = 1'b1; slt_unsigned = 1'b0;
    exp_br = 1'b1;
    g_cnt = 0;
    for (int c = 0; c < 40 && g_cnt < 4; c++) begin
      #1;
      if (br_req_ready || slt_req_ready) begin
        chk($sformatf("rr_grant%0d_is_branch", g_cnt), 32'(br_req_ready), 32'(PRIO || exp_br));
        exp_br = !exp_br;
        g_cnt++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", g_cnt, 32'd4);
    br_req_valid = 1'b0;
    slt_req_valid = 1'b0;
    pulse_reset();

    // Backpressure in RESP.
    br_req_valid = 1'b1; br_funct3 = 3'b100;
    br_rs1_data = 32'hFFFF_FFFF; br_rs2_data = 32'h0000_0001;
    br_rsp_ready = 1'b0;
    #1;
    chk("bp_accept_ready", 32'(br_req_ready), 32'd1);
    @(negedge clk);
    br_req_valid = 1'b1; slt_req_valid = 1'b1;
    br_funct3 = 3'b110; br_rs1_data = 32'h0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold%0d_valid_taken", c), 32'({br_rsp_valid, br_taken, slt_rsp_valid}), 32'd6);
      chk($sformatf("bp_hold%0d_req_ready", c), 32'({br_req_ready, slt_req_ready}), 32'd0);
      @(negedge clk);
    end
    br_rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(br_rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("bp_done_valid", 32'(br_rsp_valid), 32'd0);
    chk("bp_idle_grant", 32'({br_req_ready, slt_req_ready}), PRIO ? 32'd2 : 32'd1);
    br_req_valid = 1'b0;
    slt_req_valid = 1'b0;
    @(negedge clk);

    // Reset while in CMP drops the request.
    br_req_valid = 1'b1; br_funct3 = 3'b011;
    br_rs1_data = 32'd7; br_rs2_data = 32'd7;
    #1;
    chk("rstcmp_accept", 32'(br_req_ready), 32'd1);
    @(negedge clk);
    br_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstcmp_ready_low", 32'({br_req_ready, slt_req_ready}), 32'd0);
    @(negedge clk);
    #1;
    chk("rstcmp_rsp_cleared", 32'({br_rsp_valid, slt_rsp_valid}), 32'd0);
    chk("rstcmp_comp_cleared", comp_rs1_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstcmp_idle_ptr_branch", 32'({br_req_ready, slt_req_ready}), 32'd2);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (br_rsp_valid || slt_rsp_valid) seen = 1'b1;
    end
    chk("rstcmp_no_response", 32'(seen), 32'd0);

    // Randomized traffic against a transaction-level scoreboard.
    pulse_reset();
    busy = 1'b0; own_br = 1'b0; rr_br = 1'b1; acc_k = 0;
    exp_bt = 2'b00; exp_sr = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      br_req_valid  = 1'($urandom_range(0, 1));
      slt_req_valid = 1'($urandom_range(0, 1));
      br_funct3     = 3'($urandom_range(0, 7));
      slt_unsigned  = 1'($urandom_range(0, 1));
      br_rs2_data   = $urandom;
      br_rs1_data   = ($urandom_range(0, 3) == 0) ? br_rs2_data : $urandom;
      slt_rs2_data  = $urandom;
      slt_rs1_data  = ($urandom_range(0, 3) == 0) ? slt_rs2_data : $urandom;
      br_rsp_ready  = ($urandom_range(0, 3) != 0);
      slt_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!busy) begin
        if (br_req_valid && slt_req_valid) wbr = PRIO || rr_br;
        else if (br_req_valid)             wbr = 1'b1;
        else if (slt_req_valid)            wbr = 1'b0;
        else                               wbr = PRIO || rr_br;
        chk("rnd_idle_grant", 32'({br_req_ready, slt_req_ready}), wbr ? 32'd2 : 32'd1);
        chk("rnd_idle_rsp", 32'({br_rsp_valid, slt_rsp_valid}), 32'd0);
        if (wbr ? br_req_valid : slt_req_valid) begin
          busy   = 1'b1;
          own_br = wbr;
          acc_k  = k;
          rr_br  = !wbr;
          exp_bt = br_model(br_funct3, br_rs1_data, br_rs2_data);
          exp_sr = slt_model(slt_unsigned, slt_rs1_data, slt_rs2_data);
        end
      end else begin
        age = k - acc_k;
        chk("rnd_busy_ready", 32'({br_req_ready, slt_req_ready}), 32'd0);
        chk("rnd_rsp_valid", 32'({br_rsp_valid, slt_rsp_valid}),
            (age < 2) ? 32'd0 : (own_br ? 32'd2 : 32'd1));
        if (age >= 2) begin
          if (own_br) chk("rnd_br_result", 32'({br_taken, br_illegal}), 32'(exp_bt));
          else        chk("rnd_slt_result", 32'(slt_result), 32'(exp_sr));
          if (own_br ? br_rsp_ready : slt_rsp_ready) busy = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
